// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: operation codes,
// write/stall literals and the FSM state type.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NonStop      = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian byte-lane decode: bus lane select and store replication for
// the issue side, lane extraction and sign/zero extension for the load side.
import mem_lsu_pkg::*;

module lsu_align (
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] store_i,
    input  logic [31:0] rdata_i,
    output logic        is_mem_o,
    output logic        is_load_o,
    output logic        misaligned_o,
    output logic [3:0]  sel_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane 0 (addr 0) is the most significant byte.
    assign byte_shift = rdata_i >> {~addr_i, 3'b000};
    assign half_shift = rdata_i >> (addr_i[1] ? 5'd0 : 5'd16);
    assign byte_v     = byte_shift[7:0];
    assign half_v     = half_shift[15:0];

    always_comb begin
        is_mem_o     = 1'b0;
        is_load_o    = 1'b0;
        misaligned_o = 1'b0;
        sel_o        = 4'b0000;
        st_data_o    = store_i;
        ld_data_o    = ZeroWord;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
                sel_o     = 4'b1000 >> addr_i;
                ld_data_o = (aluop_i == EXE_LB_OP) ? {{24{byte_v[7]}}, byte_v}
                                                   : {24'h0, byte_v};
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_mem_o     = 1'b1;
                is_load_o    = 1'b1;
                misaligned_o = addr_i[0];
                sel_o        = addr_i[1] ? 4'b0011 : 4'b1100;
                ld_data_o    = (aluop_i == EXE_LH_OP) ? {{16{half_v[15]}}, half_v}
                                                      : {16'h0, half_v};
            end
            EXE_LW_OP: begin
                is_mem_o     = 1'b1;
                is_load_o    = 1'b1;
                misaligned_o = (addr_i != 2'b00);
                sel_o        = 4'b1111;
                ld_data_o    = rdata_i;
            end
            EXE_SB_OP: begin
                is_mem_o  = 1'b1;
                sel_o     = 4'b1000 >> addr_i;
                st_data_o = {4{store_i[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem_o     = 1'b1;
                misaligned_o = addr_i[0];
                sel_o        = addr_i[1] ? 4'b0011 : 4'b1100;
                st_data_o    = {2{store_i[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem_o     = 1'b1;
                misaligned_o = (addr_i != 2'b00);
                sel_o        = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while a single registered
// bus transfer is outstanding, then presents extended load data to MEM/WB.
import mem_lsu_pkg::*;

module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [5:0]  stall,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);

    lsu_state_e  state_q, state_d;
    logic [31:0] rdata_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;
    logic        start, take;

    logic        is_mem, is_load, misaligned;
    logic [3:0]  sel;
    logic [31:0] st_data, ld_data;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    lsu_align u_align (
        .aluop_i     (aluop_i),
        .addr_i      (mem_addr_i[1:0]),
        .store_i     (reg2_i),
        .rdata_i     (rdata_q),
        .is_mem_o    (is_mem),
        .is_load_o   (is_load),
        .misaligned_o(misaligned),
        .sel_o       (sel),
        .st_data_o   (st_data),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        take     = 1'b0;
        stallreq = NonStop;
        wd_o     = wd_i;
        wreg_o   = wreg_i;
        wdata_o  = wdata_i;
        hi_o     = hi_i;
        lo_o     = lo_i;
        whilo_o  = whilo_i;
        if (rst) begin
            state_d = ST_IDLE;
            wd_o    = NOPRegAddr;
            wreg_o  = WriteDisable;
            wdata_o = ZeroWord;
            hi_o    = ZeroWord;
            lo_o    = ZeroWord;
            whilo_o = WriteDisable;
        end else if (is_mem) begin
            // Register write is withheld until the load data is in hand.
            wreg_o = WriteDisable;
            if (!misaligned) begin
                case (state_q)
                    ST_IDLE: begin
                        stallreq = Stop;
                        start    = 1'b1;
                        state_d  = ST_WAIT;
                    end
                    ST_WAIT: begin
                        stallreq = Stop;
                        if (dbus_ack) begin
                            take    = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (is_load) begin
                            wreg_o  = wreg_i;
                            wdata_o = ld_data;
                        end
                        if (!stall[4]) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= ZeroWord;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ZeroWord;
            sel_q   <= 4'b0000;
            wdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= ~is_load;
                addr_q  <= {mem_addr_i[31:2], 2'b00};
                sel_q   <= sel;
                wdata_q <= st_data;
            end
            if (take) begin
                rdata_q <= dbus_rdata;
                req_q   <= 1'b0;
            end
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a vector table of single transfers plus
// hand-written sequences for delayed ack, DONE hold, misalignment and reset.
import mem_lsu_pkg::*;

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i;
    logic [5:0]  stall;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, stallreq;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_sel;
    logic        dbus_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [7:0] NOP_OP = 8'b0010_0000;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] bwdata;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .stall(stall),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o),
        .lo_o(lo_o), .whilo_o(whilo_o), .stallreq(stallreq),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = reg2;
        wd_i       = 5'd7;
        wreg_i     = 1'b1;
        wdata_i    = 32'h5555_AAAA;
        hi_i       = 32'h1111_2222;
        lo_i       = 32'h3333_4444;
        whilo_i    = 1'b1;
    endtask

    // One transfer with ack on the first WAIT cycle; starts and ends in IDLE.
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_res;
        set_op(v.op, v.addr, v.reg2);
        if (!v.we) exp_q.push_back(v.res);
        @(negedge clk);
        chk({v.name, " idle stallreq"}, 32'(stallreq), 32'd1);
        chk({v.name, " idle req"}, 32'(dbus_req), 32'd0);
        next_cycle();
        dbus_ack   = 1'b1;
        dbus_rdata = v.rdata;
        @(negedge clk);
        chk({v.name, " req"}, 32'(dbus_req), 32'd1);
        chk({v.name, " we"}, 32'(dbus_we), 32'(v.we));
        chk({v.name, " addr"}, dbus_addr, {v.addr[31:2], 2'b00});
        chk({v.name, " sel"}, 32'(dbus_sel), 32'(v.sel));
        if (v.we) chk({v.name, " bus wdata"}, dbus_wdata, v.bwdata);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk({v.name, " done stallreq"}, 32'(stallreq), 32'd0);
        chk({v.name, " done req"}, 32'(dbus_req), 32'd0);
        chk({v.name, " wreg_o"}, 32'(wreg_o), v.we ? 32'd0 : 32'd1);
        chk({v.name, " wd_o"}, 32'(wd_o), 32'd7);
        chk({v.name, " hi_o"}, hi_o, 32'h1111_2222);
        if (!v.we) begin
            exp_res = exp_q.pop_front();
            chk({v.name, " wdata_o"}, wdata_o, exp_res);
        end
        next_cycle();
        aluop_i = NOP_OP;
    endtask

    initial begin
        int sr_cnt;
        vecs[0]  = '{"LW 104",  EXE_LW_OP,  32'h104, 32'h0,         32'h1234_5678, 4'b1111, 1'b0, 32'h0, 32'h1234_5678};
        vecs[1]  = '{"LB 103",  EXE_LB_OP,  32'h103, 32'h0,         32'h0000_00F0, 4'b0001, 1'b0, 32'h0, 32'hFFFF_FFF0};
        vecs[2]  = '{"LBU 103", EXE_LBU_OP, 32'h103, 32'h0,         32'h0000_00F0, 4'b0001, 1'b0, 32'h0, 32'h0000_00F0};
        vecs[3]  = '{"LB 100",  EXE_LB_OP,  32'h100, 32'h0,         32'h7F00_0000, 4'b1000, 1'b0, 32'h0, 32'h0000_007F};
        vecs[4]  = '{"LBU 101", EXE_LBU_OP, 32'h101, 32'h0,         32'h00AB_0000, 4'b0100, 1'b0, 32'h0, 32'h0000_00AB};
        vecs[5]  = '{"LB 102",  EXE_LB_OP,  32'h102, 32'h0,         32'h0000_8500, 4'b0010, 1'b0, 32'h0, 32'hFFFF_FF85};
        vecs[6]  = '{"LH 200",  EXE_LH_OP,  32'h200, 32'h0,         32'h8001_1234, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001};
        vecs[7]  = '{"LHU 202", EXE_LHU_OP, 32'h202, 32'h0,         32'h1234_F00D, 4'b0011, 1'b0, 32'h0, 32'h0000_F00D};
        vecs[8]  = '{"LH 202",  EXE_LH_OP,  32'h202, 32'h0,         32'h1234_7FFF, 4'b0011, 1'b0, 32'h0, 32'h0000_7FFF};
        vecs[9]  = '{"SH 202",  EXE_SH_OP,  32'h202, 32'h0000_ABCD, 32'h0,         4'b0011, 1'b1, 32'hABCD_ABCD, 32'h0};
        vecs[10] = '{"SB 101",  EXE_SB_OP,  32'h101, 32'h1234_5678, 32'h0,         4'b0100, 1'b1, 32'h7878_7878, 32'h0};
        vecs[11] = '{"SW 300",  EXE_SW_OP,  32'h300, 32'hDEAD_BEEF, 32'h0,         4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0};

        rst = 1'b1;
        stall = 6'b0;
        dbus_ack = 1'b0;
        dbus_rdata = 32'h0;
        set_op(EXE_LW_OP, 32'h104, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst wd_o", 32'(wd_o), 32'(NOPRegAddr));
        chk("rst wreg_o", 32'(wreg_o), 32'd0);
        chk("rst wdata_o", wdata_o, 32'h0);
        chk("rst hi_o", hi_o, 32'h0);
        chk("rst lo_o", lo_o, 32'h0);
        chk("rst whilo_o", 32'(whilo_o), 32'd0);
        chk("rst stallreq", 32'(stallreq), 32'd0);
        chk("rst bus", {dbus_req, dbus_we, dbus_sel, dbus_addr[25:0]}, 32'h0);
        chk("rst bus wdata", dbus_wdata, 32'h0);
        chk("rst state", 32'(dut.state_q), 32'(ST_IDLE));
        aluop_i = NOP_OP;
        next_cycle();
        rst = 1'b0;

        // Non-memory op passes through with no bus activity.
        next_cycle();
        @(negedge clk);
        chk("nop wdata_o", wdata_o, 32'h5555_AAAA);
        chk("nop wreg_o", 32'(wreg_o), 32'd1);
        chk("nop wd_o", 32'(wd_o), 32'd7);
        chk("nop lo_o", lo_o, 32'h3333_4444);
        chk("nop stallreq", 32'(stallreq), 32'd0);
        next_cycle();
        chk("nop req", 32'(dbus_req), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Delayed ack: ack arrives on the fifth WAIT cycle.
        sr_cnt = 0;
        set_op(EXE_LW_OP, 32'h104, 32'h0);
        @(negedge clk);
        if (stallreq) sr_cnt++;
        next_cycle();
        for (int w = 1; w <= 5; w++) begin
            if (w == 5) begin
                dbus_ack = 1'b1;
                dbus_rdata = 32'hA5A5_0001;
            end
            @(negedge clk);
            if (stallreq) sr_cnt++;
            chk("delay bus stable", {dbus_req, dbus_we, dbus_sel, dbus_addr[25:0]},
                {1'b1, 1'b0, 4'b1111, 26'h104});
            next_cycle();
        end
        dbus_ack = 1'b0;
        @(negedge clk);
        if (stallreq) sr_cnt++;
        chk("delay stallreq cycles", 32'(sr_cnt), 32'd6);
        chk("delay state", 32'(dut.state_q), 32'(ST_DONE));
        chk("delay wdata_o", wdata_o, 32'hA5A5_0001);
        next_cycle();
        aluop_i = NOP_OP;

        // DONE holds while stall[4] is set.
        set_op(EXE_LHU_OP, 32'h200, 32'h0);
        next_cycle();
        dbus_ack = 1'b1;
        dbus_rdata = 32'hBEEF_0000;
        next_cycle();
        dbus_ack = 1'b0;
        stall = 6'b011111;
        next_cycle();
        chk("hold state 1", 32'(dut.state_q), 32'(ST_DONE));
        chk("hold wdata_o", wdata_o, 32'h0000_BEEF);
        next_cycle();
        chk("hold state 2", 32'(dut.state_q), 32'(ST_DONE));
        stall = 6'b0;
        next_cycle();
        aluop_i = NOP_OP;
        chk("hold release", 32'(dut.state_q), 32'(ST_IDLE));

        // Misaligned accesses are suppressed.
        set_op(EXE_LW_OP, 32'h101, 32'h0);
        @(negedge clk);
        chk("misal lw stallreq", 32'(stallreq), 32'd0);
        chk("misal lw wreg_o", 32'(wreg_o), 32'd0);
        next_cycle();
        chk("misal lw req", 32'(dbus_req), 32'd0);
        set_op(EXE_SH_OP, 32'h201, 32'h1234);
        @(negedge clk);
        chk("misal sh stallreq", 32'(stallreq), 32'd0);
        next_cycle();
        chk("misal sh req", 32'(dbus_req), 32'd0);
        chk("misal sh state", 32'(dut.state_q), 32'(ST_IDLE));
        aluop_i = NOP_OP;
        next_cycle();

        // Reset while WAIT abandons the transfer; the late ack is ignored.
        set_op(EXE_LW_OP, 32'h400, 32'h0);
        next_cycle();
        chk("rstwait req", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        aluop_i = NOP_OP;
        next_cycle();
        chk("rstwait req drop", 32'(dbus_req), 32'd0);
        chk("rstwait state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 32'hCAFE_F00D;
        next_cycle();
        dbus_ack = 1'b0;
        chk("late ack state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("late ack capture", dut.rdata_q, 32'h0);
        chk("late ack req", 32'(dbus_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
